// File: rtl/hdmi_pkg.sv
// Shared period-mode encoding, control-character constants and island timing
// lengths for the HDMI transmit period scheduler.
package hdmi_pkg;

  typedef enum logic [2:0] {
    PM_CTRL        = 3'd0,
    PM_VID_PRE     = 3'd1,
    PM_VID_GB      = 3'd2,
    PM_VIDEO       = 3'd3,
    PM_DI_PRE      = 3'd4,
    PM_DI_GB_LEAD  = 3'd5,
    PM_DI_DATA     = 3'd6,
    PM_DI_GB_TRAIL = 3'd7
  } periodMode_t;

  typedef enum logic [2:0] {
    ISL_IDLE,
    ISL_PRE,
    ISL_GBL,
    ISL_DATA,
    ISL_GBT
  } islandState_t;

  localparam logic [3:0] CTL_NONE    = '0;
  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] CTL_DI_PRE  = 4'b0101;

  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned GUARD_LEN    = 2;
  localparam int unsigned PACKET_LEN   = 32;

  function automatic logic [3:0] ctlFor(input periodMode_t mode);
    case (mode)
      PM_VID_PRE: ctlFor = CTL_VID_PRE;
      PM_DI_PRE:  ctlFor = CTL_DI_PRE;
      default:    ctlFor = CTL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Horizontal/vertical raster counters with registered syncs; also exposes the
// position of the following cycle so the top can register matching outputs.
module hdmi_raster_counter
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned HSYNC_POL = 0,
  parameter int unsigned VSYNC_POL = 0
) (
  input  logic        pixelClock,
  input  logic        reset,
  output logic [11:0] hCount,
  output logic [10:0] vCount,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] nextH,
  output logic [10:0] nextV
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEGIN = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic        HS_ON    = (HSYNC_POL != 0);
  localparam logic        VS_ON    = (VSYNC_POL != 0);

  always_comb begin
    nextH = hCount + 12'd1;
    nextV = vCount;
    if (hCount == H_LAST) begin
      nextH = '0;
      nextV = (vCount == V_LAST) ? '0 : vCount + 11'd1;
    end
  end

  // Syncs are decoded from the next position so they line up with the counters.
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
      hsync  <= ~HS_ON;
      vsync  <= ~VS_ON;
    end else begin
      hCount <= nextH;
      vCount <= nextV;
      hsync  <= (nextH >= HS_BEGIN && nextH < HS_END) ? HS_ON : ~HS_ON;
      vsync  <= (nextV >= VS_BEGIN && nextV < VS_END) ? VS_ON : ~VS_ON;
    end
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Raster and HDMI period sequencer: decodes video/control periods and schedules
// queued packets into horizontal-blanking data islands.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter int unsigned HSYNC_POL    = 0,
  parameter int unsigned VSYNC_POL    = 0,
  parameter int unsigned ISLAND_START = 652,
  parameter int unsigned MAX_PACKETS  = 2
) (
  input  logic        pixelClock,
  input  logic        reset,
  input  logic        packetValid,
  output logic [11:0] hCount,
  output logic [10:0] vCount,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  periodMode,
  output logic [3:0]  ctl,
  output logic        packetStart,
  output logic [4:0]  packetWord
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (ISLAND_START < H_ACTIVE + 12 ||
      ISLAND_START + 12 + 32 * MAX_PACKETS > H_TOTAL - 22 ||
      MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : gBadConfig
    $error("hdmi_period_scheduler: data island does not fit in horizontal blanking");
  end

  localparam logic [11:0] DECIDE_H   = 12'(ISLAND_START - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] VPRE_FIRST = 12'(H_TOTAL - 10);
  localparam logic [11:0] VPRE_LAST  = 12'(H_TOTAL - 3);
  localparam logic [11:0] VGB_FIRST  = 12'(H_TOTAL - 2);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_PRE_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [4:0]  MAX_PKT    = 5'(MAX_PACKETS);
  localparam logic [4:0]  PRE_LAST   = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]  GUARD_LAST = 5'(GUARD_LEN - 1);
  localparam logic [4:0]  WORD_LAST  = 5'(PACKET_LEN - 1);

  logic [11:0]  nextH;
  logic [10:0]  nextV;
  islandState_t state, stateN;
  logic [4:0]   cnt, cntN;
  logic [4:0]   pktCount, pktN;
  logic [4:0]   wordN;
  logic         startN;
  logic         videoOn, videoOnN;
  logic         leadIn;
  periodMode_t  modeN;

  hdmi_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .HSYNC_POL(HSYNC_POL),
    .VSYNC_POL(VSYNC_POL)
  ) uRaster (
    .pixelClock(pixelClock),
    .reset     (reset),
    .hCount    (hCount),
    .vCount    (vCount),
    .hsync     (hsync),
    .vsync     (vsync),
    .nextH     (nextH),
    .nextV     (nextV)
  );

  // Island sequencing: packetValid matters only at the decision column and on
  // the last word of each packet.
  always_comb begin
    stateN = state;
    cntN   = cnt;
    pktN   = pktCount;
    wordN  = '0;
    startN = 1'b0;
    case (state)
      ISL_IDLE: begin
        if (hCount == DECIDE_H && packetValid) begin
          stateN = ISL_PRE;
          cntN   = '0;
          pktN   = '0;
        end
      end
      ISL_PRE: begin
        if (cnt == PRE_LAST) begin
          stateN = ISL_GBL;
          cntN   = '0;
        end else begin
          cntN = cnt + 5'd1;
        end
      end
      ISL_GBL: begin
        if (cnt == GUARD_LAST) begin
          stateN = ISL_DATA;
          pktN   = 5'd1;
          startN = 1'b1;
        end else begin
          cntN = cnt + 5'd1;
        end
      end
      ISL_DATA: begin
        if (packetWord != WORD_LAST) begin
          wordN = packetWord + 5'd1;
        end else if (packetValid && pktCount < MAX_PKT) begin
          pktN   = pktCount + 5'd1;
          startN = 1'b1;
        end else begin
          stateN = ISL_GBT;
          cntN   = '0;
        end
      end
      ISL_GBT: begin
        if (cnt == GUARD_LAST) stateN = ISL_IDLE;
        else                   cntN = cnt + 5'd1;
      end
      default: stateN = ISL_IDLE;
    endcase
  end

  // Video is held off after reset until the raster wraps to the next frame.
  always_comb begin
    videoOnN = videoOn | (nextH == '0 && nextV == '0);
    leadIn   = (nextV == V_LAST) || (videoOnN && nextV < V_PRE_LAST);
    modeN    = PM_CTRL;
    case (stateN)
      ISL_PRE:  modeN = PM_DI_PRE;
      ISL_GBL:  modeN = PM_DI_GB_LEAD;
      ISL_DATA: modeN = PM_DI_DATA;
      ISL_GBT:  modeN = PM_DI_GB_TRAIL;
      default: begin
        if (videoOnN && nextH < H_ACT && nextV < V_ACT)
          modeN = PM_VIDEO;
        else if (leadIn && nextH >= VPRE_FIRST && nextH <= VPRE_LAST)
          modeN = PM_VID_PRE;
        else if (leadIn && nextH >= VGB_FIRST)
          modeN = PM_VID_GB;
      end
    endcase
  end

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      state       <= ISL_IDLE;
      cnt         <= '0;
      pktCount    <= '0;
      videoOn     <= 1'b0;
      periodMode  <= PM_CTRL;
      ctl         <= CTL_NONE;
      packetStart <= 1'b0;
      packetWord  <= '0;
    end else begin
      state       <= stateN;
      cnt         <= cntN;
      pktCount    <= pktN;
      videoOn     <= videoOnN;
      periodMode  <= modeN;
      ctl         <= ctlFor(modeN);
      packetStart <= startN;
      packetWord  <= wordN;
    end
  end

endmodule
